// File: rtl/seq_ctrl_pkg.sv
// Shared definitions for seq_controller: FSM state encoding and opcode constants
// derived from the opcode field width.
package seq_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_HALT  = 2'd2
   } state_t;

   localparam int unsigned OP_NOP = 0;

   // HALT is the all-ones opcode, JMP sits directly below it.
   function automatic int unsigned op_halt(input int unsigned w);
      return (32'd1 << w) - 32'd1;
   endfunction

   function automatic int unsigned op_jmp(input int unsigned w);
      return op_halt(w) - 32'd1;
   endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode decode: one-hot register load, JMP, HALT and illegal flags.
module seq_decode
   import seq_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 4,
   parameter int NUM_REGS = 3
) (
   input  logic [OPCODE_W-1:0] opcode,
   output logic [NUM_REGS-1:0] load,
   output logic                is_jmp,
   output logic                is_halt,
   output logic                is_illegal
);

   localparam logic [OPCODE_W-1:0] NOP_CODE  = OPCODE_W'(OP_NOP);
   localparam logic [OPCODE_W-1:0] JMP_CODE  = OPCODE_W'(op_jmp(OPCODE_W));
   localparam logic [OPCODE_W-1:0] HALT_CODE = OPCODE_W'(op_halt(OPCODE_W));

   logic is_nop;
   logic is_load;

   // NOTE: every output gets a default before the decode so no path can infer a latch.
   always_comb begin
      load    = '0;
      is_load = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (opcode == OPCODE_W'(i + 1)) begin
            load[i] = 1'b1;
            is_load = 1'b1;
         end
      end
      is_nop     = (opcode == NOP_CODE);
      is_jmp     = (opcode == JMP_CODE);
      is_halt    = (opcode == HALT_CODE);
      is_illegal = !(is_nop || is_load || is_jmp || is_halt);
   end

endmodule

// File: rtl/seq_controller.sv
// Two-phase (FETCH/EXEC) instruction sequencer with HALT/resume.
// Define SEQ_CONTROLLER_ILLEGAL_TRAP_EN to trap illegal opcodes into HALT.
module seq_controller
   import seq_ctrl_pkg::*;
#(
   parameter int OPCODE_W = 4,
   parameter int NUM_REGS = 3,
   parameter int ADDR_W   = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                instr_valid,
   output logic                instr_ready,
   input  logic [OPCODE_W-1:0] opcode,
   input  logic [ADDR_W-1:0]   operand,
   input  logic                resume,
   output logic [NUM_REGS-1:0] load_reg,
   output logic [ADDR_W-1:0]   pc,
   output logic                halted,
   output logic                illegal_op,
   output logic [15:0]         retired
);

`ifdef SEQ_CONTROLLER_ILLEGAL_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   state_t              state;
   state_t              next_state;
   logic [OPCODE_W-1:0] op_q;
   logic [ADDR_W-1:0]   operand_q;
   logic [NUM_REGS-1:0] dec_load;
   logic                dec_jmp;
   logic                dec_halt;
   logic                dec_illegal;
   logic                accept;
   logic                exec;
   logic                trap;

   seq_decode #(
      .OPCODE_W (OPCODE_W),
      .NUM_REGS (NUM_REGS)
   ) u_decode (
      .opcode     (op_q),
      .load       (dec_load),
      .is_jmp     (dec_jmp),
      .is_halt    (dec_halt),
      .is_illegal (dec_illegal)
   );

   assign accept = instr_valid && instr_ready;
   assign exec   = (state == ST_EXEC);
   assign trap   = TRAP_EN && dec_illegal;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_FETCH;
      else        state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         ST_FETCH: if (accept) next_state = ST_EXEC;
         ST_EXEC:  next_state = (dec_halt || trap) ? ST_HALT : ST_FETCH;
         ST_HALT:  if (resume) next_state = ST_FETCH;
         default:  next_state = ST_FETCH;
      endcase
   end

   // Ready is qualified by rst_n so it drops the moment reset asserts.
   always_comb begin
      instr_ready = rst_n && (state == ST_FETCH);
      halted      = (state == ST_HALT);
      load_reg    = exec ? dec_load : '0;
   end

   // NOTE: the capture registers are reset too, so decode never sees X straight after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q      <= '0;
         operand_q <= '0;
         pc        <= '0;
         retired   <= '0;
      end else begin
         if (accept) begin
            op_q      <= opcode;
            operand_q <= operand;
         end
         if (exec) begin
            if (retired != 16'hFFFF) retired <= retired + 16'd1;
            if (dec_jmp)    pc <= operand_q;
            else if (!trap) pc <= pc + ADDR_W'(1);
         end
      end
   end

`ifdef SEQ_CONTROLLER_ILLEGAL_TRAP_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)          illegal_op <= 1'b0;
      else if (exec && trap) illegal_op <= 1'b1;
   end
`else
   assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_seq_controller.sv
// Self-checking bench for seq_controller: directed vector table, reset corner
// cases, and random instruction streams against an instruction-level model.
module tb_seq_controller;

   localparam int OPCODE_W = 4;
   localparam int NUM_REGS = 3;
   localparam int ADDR_W   = 8;
   localparam int OP_JMP   = (1 << OPCODE_W) - 2;
   localparam int OP_HALT  = (1 << OPCODE_W) - 1;

`ifdef SEQ_CONTROLLER_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic                clk;
   logic                rst_n;
   logic                instr_valid;
   logic                instr_ready;
   logic [OPCODE_W-1:0] opcode;
   logic [ADDR_W-1:0]   operand;
   logic                resume;
   logic [NUM_REGS-1:0] load_reg;
   logic [ADDR_W-1:0]   pc;
   logic                halted;
   logic                illegal_op;
   logic [15:0]         retired;

   seq_controller #(
      .OPCODE_W (OPCODE_W),
      .NUM_REGS (NUM_REGS),
      .ADDR_W   (ADDR_W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .opcode      (opcode),
      .operand     (operand),
      .resume      (resume),
      .load_reg    (load_reg),
      .pc          (pc),
      .halted      (halted),
      .illegal_op  (illegal_op),
      .retired     (retired)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Instruction-level reference model
   int m_pc;
   int m_retired;
   bit m_halt;
   bit m_ill;

   typedef struct {
      int             op;
      int             opnd;
      logic [2:0]     load;
      logic [7:0]     exp_pc;
      bit             halt;
      bit             ill;
   } vec_t;

   vec_t tbl [9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic bit is_load(input int op);
      return (op >= 1) && (op <= NUM_REGS);
   endfunction

   function automatic logic [NUM_REGS-1:0] exp_load(input int op);
      logic [NUM_REGS-1:0] v;
      v = '0;
      if (is_load(op)) v[op-1] = 1'b1;
      return v;
   endfunction

   task automatic model_reset();
      m_pc = 0; m_retired = 0; m_halt = 1'b0; m_ill = 1'b0;
   endtask

   task automatic model_exec(input int op, input int opnd);
      if (m_retired < 65535) m_retired++;
      if (op == OP_JMP) m_pc = opnd;
      else if (op == OP_HALT) begin
         m_pc = (m_pc + 1) % (1 << ADDR_W);
         m_halt = 1'b1;
      end else if (op == 0 || is_load(op) || !TRAP) m_pc = (m_pc + 1) % (1 << ADDR_W);
      else begin
         m_ill = 1'b1;
         m_halt = 1'b1;
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, "_pc"},      pc,          m_pc);
      check({tag, "_retired"}, retired,     m_retired);
      check({tag, "_halted"},  halted,      m_halt);
      check({tag, "_illegal"}, illegal_op,  m_ill);
      check({tag, "_ready"},   instr_ready, !m_halt);
      check({tag, "_load0"},   load_reg,    0);
   endtask

   // Called just after an edge with the controller in FETCH.
   task automatic run_instr(input int op, input int opnd, input logic [NUM_REGS-1:0] want_load,
                            input string tag);
      check({tag, "_rdy_fetch"}, instr_ready, 1);
      instr_valid = 1'b1;
      opcode      = OPCODE_W'(op);
      operand     = ADDR_W'(opnd);
      tick();
      instr_valid = 1'($urandom_range(0, 1));
      opcode      = OPCODE_W'($urandom);
      operand     = ADDR_W'($urandom);
      check({tag, "_load"},     load_reg,    want_load);
      check({tag, "_rdy_exec"}, instr_ready, 0);
      tick();
      instr_valid = 1'b0;
      model_exec(op, opnd);
      check_state(tag);
   endtask

   task automatic leave_halt(input string tag);
      for (int i = 0; i < 2; i++) begin
         instr_valid = 1'b1;
         opcode      = OPCODE_W'($urandom_range(1, NUM_REGS));
         tick();
         check({tag, "_hold_halted"}, halted,      1);
         check({tag, "_hold_ready"},  instr_ready, 0);
         check({tag, "_hold_pc"},     pc,          m_pc);
         check({tag, "_hold_load"},   load_reg,    0);
      end
      instr_valid = 1'b0;
      resume      = 1'b1;
      tick();
      resume = 1'b0;
      m_halt = 1'b0;
      check_state({tag, "_resume"});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         instr_valid = 1'b0;
         resume      = 1'($urandom_range(0, 1));
         tick();
         resume = 1'b0;
         check_state("idle");
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0] = '{1,  8'h12, 3'b001, 8'h01, 1'b0, 1'b0};
      tbl[1] = '{2,  8'h34, 3'b010, 8'h02, 1'b0, 1'b0};
      tbl[2] = '{3,  8'h56, 3'b100, 8'h03, 1'b0, 1'b0};
      tbl[3] = '{14, 8'h40, 3'b000, 8'h40, 1'b0, 1'b0};
      tbl[4] = '{0,  8'h99, 3'b000, 8'h41, 1'b0, 1'b0};
      tbl[5] = '{14, 8'hFF, 3'b000, 8'hFF, 1'b0, 1'b0};
      tbl[6] = '{0,  8'h00, 3'b000, 8'h00, 1'b0, 1'b0};
`ifdef SEQ_CONTROLLER_ILLEGAL_TRAP_EN
      tbl[7] = '{7,  8'h55, 3'b000, 8'h00, 1'b1, 1'b1};
      tbl[8] = '{15, 8'hAA, 3'b000, 8'h01, 1'b1, 1'b1};
`else
      tbl[7] = '{7,  8'h55, 3'b000, 8'h01, 1'b0, 1'b0};
      tbl[8] = '{15, 8'hAA, 3'b000, 8'h02, 1'b1, 1'b0};
`endif

      instr_valid = 1'b0;
      opcode      = '0;
      operand     = '0;
      resume      = 1'b0;
      rst_n       = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_ready",   instr_ready, 0);
      check("rst_load",    load_reg,    0);
      check("rst_pc",      pc,          0);
      check("rst_halted",  halted,      0);
      check("rst_illegal", illegal_op,  0);
      check("rst_retired", retired,     0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      tick();
      check("release_ready", instr_ready, 1);

      // Directed vector table from reset
      for (int i = 0; i < 9; i++) begin
         run_instr(tbl[i].op, tbl[i].opnd, tbl[i].load, $sformatf("vec%0d", i));
         check($sformatf("vec%0d_tbl_pc", i),      pc,         tbl[i].exp_pc);
         check($sformatf("vec%0d_tbl_halt", i),    halted,     tbl[i].halt);
         check($sformatf("vec%0d_tbl_ill", i),     illegal_op, tbl[i].ill);
         check($sformatf("vec%0d_tbl_retired", i), retired,    i + 1);
         if (m_halt) leave_halt($sformatf("vec%0d", i));
      end

      // Reset asserted while a LOAD is executing
      instr_valid = 1'b1;
      opcode      = 4'd2;
      operand     = 8'h77;
      tick();
      instr_valid = 1'b0;
      check("midexec_load", load_reg, 3'b010);
      rst_n = 1'b0;
      #1;
      model_reset();
      check("midexec_rst_load",    load_reg,    0);
      check("midexec_rst_pc",      pc,          0);
      check("midexec_rst_retired", retired,     0);
      check("midexec_rst_ready",   instr_ready, 0);
      check("midexec_rst_illegal", illegal_op,  0);
      @(negedge clk) rst_n = 1'b1;
      tick();
      check_state("midexec_release");

      // Random instruction stream
      for (int i = 0; i < 300; i++) begin
         int op;
         int opnd;
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
         op   = $urandom_range(0, OP_HALT);
         opnd = $urandom_range(0, (1 << ADDR_W) - 1);
         run_instr(op, opnd, exp_load(op), "rand");
         if (m_halt) leave_halt("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 SHALL have parameter OPCODE_W, default 4, opcode field width.
REQ-002 SHALL have parameter NUM_REGS, default 3, number of loadable registers; legal range 1 to 2^OPCODE_W-3.
REQ-003 SHALL have parameter ADDR_W, default 8, program-counter and jump-operand width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port instr_valid  input  1  instruction present on opcode/operand.
REQ-007 SHALL have port instr_ready  output  1  controller accepts an instruction this cycle.
REQ-008 SHALL have port opcode  input  OPCODE_W  instruction opcode.
REQ-009 SHALL have port operand  input  ADDR_W  jump target; ignored by other opcodes.
REQ-010 SHALL have port resume  input  1  single-cycle pulse leaving HALT.
REQ-011 SHALL have port load_reg  output  NUM_REGS  one-hot register load strobes.
REQ-012 SHALL have port pc  output  ADDR_W  current program counter.
REQ-013 SHALL have port halted  output  1  high while in HALT.
REQ-014 SHALL have port illegal_op  output  1  sticky illegal-opcode flag.
REQ-015 SHALL have port retired  output  16  count of executed instructions.

Function
REQ-016 SHALL implement FSM states FETCH, EXEC, HALT; instr_ready = 1 only in FETCH.
REQ-017 SHALL capture opcode/operand on FETCH with instr_valid&instr_ready, then go to EXEC next cycle; stay in FETCH otherwise.
REQ-018 SHALL decode: 0 = NOP; 1..NUM_REGS = LOAD register (opcode-1); all-ones-minus-1 = JMP; all-ones = HALT; every other value illegal.
REQ-019 SHALL, in EXEC for a LOAD, drive load_reg[opcode-1] high for exactly that one cycle; load_reg SHALL be zero in all other cycles and states.
REQ-020 SHALL, on leaving EXEC, set pc <= operand for JMP, else pc <= pc+1, wrapping modulo 2^ADDR_W.
REQ-021 SHALL return EXEC->FETCH for NOP/LOAD/JMP; EXEC->HALT for HALT; throughput one instruction per two cycles.
REQ-022 SHALL increment retired once per EXEC cycle, saturating at 16'hFFFF.
REQ-023 SHALL hold pc in HALT; resume in HALT moves to FETCH next cycle; resume outside HALT ignored.
REQ-024 SHALL ignore instr_valid and opcode changes in EXEC and HALT.

Reset
REQ-025 SHALL, while rst_n low, force state FETCH, instr_ready 0, load_reg 0, pc 0, halted 0, illegal_op 0, retired 0, immediately regardless of clk.
REQ-026 SHALL, on reset mid-EXEC, drop the pending load strobe with no pc or retired update.
REQ-027 SHALL assert instr_ready in the first cycle after rst_n deasserts.

Configuration
REQ-028 SHALL honour macro SEQ_CONTROLLER_ILLEGAL_TRAP_EN: defined -> illegal opcode in EXEC sets illegal_op (sticky until reset) and enters HALT with pc unchanged; undefined -> illegal opcode executes as NOP and illegal_op is tied 0.

Structure
REQ-029 SHALL place state-encoding typedef and opcode constants (NOP, JMP, HALT as functions of OPCODE_W) in shared package seq_ctrl_pkg.
REQ-030 SHALL isolate opcode decode in one combinational sub-module seq_decode producing one-hot load, is_jmp, is_halt, is_illegal.

Verification
REQ-031 SHALL cover: reset release, opcode=1 accepted -> load_reg=3'b001 for one cycle two edges later, pc 0->1, retired=1.
REQ-032 SHALL cover: opcode=4'hE, operand=8'h40 -> pc=8'h40, load_reg stays 0.
REQ-033 SHALL cover: pc=8'hFF, NOP -> pc=8'h00.
REQ-034 SHALL cover: opcode=4'hF -> halted=1, instr_ready=0, valid ignored; resume pulse -> FETCH next cycle, halted=0.
REQ-035 SHALL cover: opcode=4'h7 with macro -> illegal_op=1, halted=1, pc unchanged; without macro -> NOP, pc+1, illegal_op=0.
REQ-036 SHALL cover: rst_n low during EXEC of opcode=2 -> load_reg=0 immediately, pc=0, retired=0.
